// File: rtl/pipeline_hazard_controller.sv
// Front-end hazard sequencer for the RV32IM IF/ID/EX pipeline.
// Generates PC/IF-ID stall, ID/EX bubble, front-end flush and divider
// hold controls from the ID operand fields and the EX-stage status.
//
// Ports:
//   CLK, RST            clock (rising edge), async active-low reset
//   ID_RS1/ID_RS2       source register fields of the ID instruction
//   ID_USES_RS1/RS2     ID instruction actually reads that operand
//   EX_RD, EX_MEM_READ  destination / load flag of the EX instruction
//   EX_DIV              EX holds DIV/DIVU/REM/REMU
//   EX_BRANCH_TAKEN     redirect resolved in EX this cycle
//   PC_STALL, IF_ID_STALL, ID_EX_BUBBLE, EX_STALL   stall controls
//   IF_ID_FLUSH, ID_EX_FLUSH                         flush controls
//   DIV_START, DIV_BUSY                              divider handshake
//   STATE                                            debug state
//
// state      | meaning
// -----------+----------------------------------------------------
// RUN        | normal flow; branch, divide and load-use decided here
// LOAD_STALL | bubble sits in EX, hazard not re-evaluated
// DIV_WAIT   | divider counting down, front end and EX held
// DIV_DONE   | divide result leaving EX, EX_DIV ignored

module pipeline_hazard_controller #(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [4:0] ID_RS1,
   input  logic [4:0] ID_RS2,
   input  logic       ID_USES_RS1,
   input  logic       ID_USES_RS2,
   input  logic [4:0] EX_RD,
   input  logic       EX_MEM_READ,
   input  logic       EX_DIV,
   input  logic       EX_BRANCH_TAKEN,
   output logic       PC_STALL,
   output logic       IF_ID_STALL,
   output logic       ID_EX_BUBBLE,
   output logic       EX_STALL,
   output logic       IF_ID_FLUSH,
   output logic       ID_EX_FLUSH,
   output logic       DIV_START,
   output logic       DIV_BUSY,
   output logic [1:0] STATE
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      DIV_WAIT   = 2'd2,
      DIV_DONE   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;

   logic w_hazard;
   logic w_pc_stall, w_if_id_stall, w_id_ex_bubble, w_ex_stall;
   logic w_if_id_flush, w_id_ex_flush, w_div_start, w_div_busy;

   // x0 is hardwired to zero, so a load targeting it never creates a dependency
   assign w_hazard = EX_MEM_READ && (EX_RD != 5'd0) &&
                     ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                      (ID_USES_RS2 && (ID_RS2 == EX_RD)));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            RUN: begin
               if (EX_BRANCH_TAKEN) begin
                  r_state <= RUN;
               end else if (EX_DIV) begin
                  r_cnt   <= DIV_LOAD;
                  r_state <= (DIV_CYCLES == 1) ? DIV_DONE : DIV_WAIT;
               end else if (w_hazard) begin
                  r_state <= LOAD_STALL;
               end
            end
            LOAD_STALL: r_state <= RUN;
            DIV_WAIT: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) r_state <= DIV_DONE;
            end
            DIV_DONE: r_state <= RUN;
            default:  r_state <= RUN;
         endcase
      end
   end

   always_comb begin
      w_pc_stall     = 1'b0;
      w_if_id_stall  = 1'b0;
      w_id_ex_bubble = 1'b0;
      w_ex_stall     = 1'b0;
      w_if_id_flush  = 1'b0;
      w_id_ex_flush  = 1'b0;
      w_div_start    = 1'b0;
      w_div_busy     = 1'b0;
      case (r_state)
         RUN: begin
            if (EX_BRANCH_TAKEN) begin
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
            end else if (EX_DIV) begin
               w_div_start   = 1'b1;
               w_div_busy    = 1'b1;
               w_pc_stall    = 1'b1;
               w_if_id_stall = 1'b1;
               w_ex_stall    = 1'b1;
            end else if (w_hazard) begin
               w_pc_stall     = 1'b1;
               w_if_id_stall  = 1'b1;
               w_id_ex_bubble = 1'b1;
            end
         end
         LOAD_STALL: begin
            w_if_id_flush = EX_BRANCH_TAKEN;
            w_id_ex_flush = EX_BRANCH_TAKEN;
         end
         DIV_WAIT: begin
            w_pc_stall    = 1'b1;
            w_if_id_stall = 1'b1;
            w_ex_stall    = 1'b1;
            w_div_busy    = 1'b1;
         end
         default: ;
      endcase
   end

   // Outputs are gated by reset so they drop immediately, even mid-divide
   assign PC_STALL     = w_pc_stall     & RST;
   assign IF_ID_STALL  = w_if_id_stall  & RST;
   assign ID_EX_BUBBLE = w_id_ex_bubble & RST;
   assign EX_STALL     = w_ex_stall     & RST;
   assign IF_ID_FLUSH  = w_if_id_flush  & RST;
   assign ID_EX_FLUSH  = w_id_ex_flush  & RST;
   assign DIV_START    = w_div_start    & RST;
   assign DIV_BUSY     = w_div_busy     & RST;
   assign STATE        = r_state & {2{RST}};

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios plus
// randomized traffic against a cycle-count reference model. Two instances
// share the inputs: DIV_CYCLES=32 (a_*) and DIV_CYCLES=1 (b_*).

module tb_pipeline_hazard_controller;

   logic       CLK;
   logic       RST;
   logic [4:0] ID_RS1, ID_RS2, EX_RD;
   logic       ID_USES_RS1, ID_USES_RS2, EX_MEM_READ, EX_DIV, EX_BRANCH_TAKEN;

   logic       a_pc, a_ifid, a_bub, a_exs, a_iff, a_idf, a_start, a_busy;
   logic [1:0] a_state;
   logic       b_pc, b_ifid, b_bub, b_exs, b_iff, b_idf, b_start, b_busy;
   logic [1:0] b_state;

   logic [9:0] obs [2];
   assign obs[0] = {a_state, a_pc, a_ifid, a_bub, a_exs, a_iff, a_idf, a_start, a_busy};
   assign obs[1] = {b_state, b_pc, b_ifid, b_bub, b_exs, b_iff, b_idf, b_start, b_busy};

   int pass_cnt = 0;
   int tot_cnt  = 0;

   pipeline_hazard_controller #(.DIV_CYCLES(32), .CNT_W(6)) u_dut (
      .CLK(CLK), .RST(RST),
      .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
      .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
      .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ), .EX_DIV(EX_DIV),
      .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
      .PC_STALL(a_pc), .IF_ID_STALL(a_ifid), .ID_EX_BUBBLE(a_bub),
      .EX_STALL(a_exs), .IF_ID_FLUSH(a_iff), .ID_EX_FLUSH(a_idf),
      .DIV_START(a_start), .DIV_BUSY(a_busy), .STATE(a_state)
   );

   pipeline_hazard_controller #(.DIV_CYCLES(1), .CNT_W(6)) u_dut1 (
      .CLK(CLK), .RST(RST),
      .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
      .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
      .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ), .EX_DIV(EX_DIV),
      .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
      .PC_STALL(b_pc), .IF_ID_STALL(b_ifid), .ID_EX_BUBBLE(b_bub),
      .EX_STALL(b_exs), .IF_ID_FLUSH(b_iff), .ID_EX_FLUSH(b_idf),
      .DIV_START(b_start), .DIV_BUSY(b_busy), .STATE(b_state)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: remaining divide stall cycles, plus two one-cycle
   // flags for "bubble in EX" and "divide result leaving EX".
   int dc     [2] = '{32, 1};
   int m_left [2] = '{0, 0};
   bit m_tail [2] = '{0, 0};
   bit m_load [2] = '{0, 0};

   function automatic bit model_hazard();
      if (!EX_MEM_READ || EX_RD == 5'd0) return 1'b0;
      return (ID_USES_RS1 && ID_RS1 == EX_RD) || (ID_USES_RS2 && ID_RS2 == EX_RD);
   endfunction

   // returns {state, pc, ifid, bubble, exstall, iff, idf, start, busy}
   function automatic logic [9:0] model_out(int k);
      logic [1:0] st;
      logic pc, ifid, bub, exs, fl, start, busy;
      st = 2'd0; pc = 0; ifid = 0; bub = 0; exs = 0; fl = 0; start = 0; busy = 0;
      if (RST !== 1'b1) return 10'd0;
      if (m_left[k] > 0) begin
         st = 2'd2; pc = 1; ifid = 1; exs = 1; busy = 1;
      end else if (m_tail[k]) begin
         st = 2'd3;
      end else if (m_load[k]) begin
         st = 2'd1; fl = EX_BRANCH_TAKEN;
      end else if (EX_BRANCH_TAKEN) begin
         fl = 1;
      end else if (EX_DIV) begin
         start = 1; busy = 1; pc = 1; ifid = 1; exs = 1;
      end else if (model_hazard()) begin
         pc = 1; ifid = 1; bub = 1;
      end
      return {st, pc, ifid, bub, exs, fl, fl, start, busy};
   endfunction

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (RST !== 1'b1) begin
            m_left[k] = 0; m_tail[k] = 0; m_load[k] = 0;
         end else if (m_left[k] > 0) begin
            m_left[k]--;
            if (m_left[k] == 0) m_tail[k] = 1;
         end else if (m_tail[k]) begin
            m_tail[k] = 0;
         end else if (m_load[k]) begin
            m_load[k] = 0;
         end else if (!EX_BRANCH_TAKEN) begin
            if (EX_DIV) begin
               m_left[k] = dc[k] - 1;
               if (m_left[k] == 0) m_tail[k] = 1;
            end else if (model_hazard()) begin
               m_load[k] = 1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic clear_inputs();
      ID_RS1 = 0; ID_RS2 = 0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
      EX_RD = 0; EX_MEM_READ = 0; EX_DIV = 0; EX_BRANCH_TAKEN = 0;
   endtask

   task automatic drain(int n);
      clear_inputs();
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      RST = 1'b0;
      clear_inputs();
      EX_MEM_READ = 1; EX_RD = 5; ID_RS1 = 5; ID_USES_RS1 = 1; EX_DIV = 1;
      #2;
      tot_cnt++;
      if (obs[0] !== 10'd0) $display("FAIL reset_outputs_a: got %h want 000", obs[0]);
      else pass_cnt++;
      tot_cnt++;
      if (obs[1] !== 10'd0) $display("FAIL reset_outputs_b: got %h want 000", obs[1]);
      else pass_cnt++;
      tick(); tick();
      RST = 1'b1;
      clear_inputs();
      @(negedge CLK);
      tot_cnt++;
      if (a_state !== 2'd0 || a_pc !== 1'b0) $display("FAIL reset_release: state=%0d pc=%b want 0/0", a_state, a_pc);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_load_use();
      clear_inputs();
      EX_MEM_READ = 1; EX_RD = 5; ID_RS1 = 5; ID_USES_RS1 = 1;
      @(negedge CLK);
      tot_cnt++;
      if ({a_pc, a_ifid, a_bub, a_state} !== {3'b111, 2'd0})
         $display("FAIL load_use_stall: pc/ifid/bub/state=%b%b%b/%0d want 111/0", a_pc, a_ifid, a_bub, a_state);
      else pass_cnt++;
      tick();
      @(negedge CLK);
      tot_cnt++;
      if ({a_pc, a_ifid, a_bub, a_state} !== {3'b000, 2'd1})
         $display("FAIL load_use_hold: pc/ifid/bub/state=%b%b%b/%0d want 000/1", a_pc, a_ifid, a_bub, a_state);
      else pass_cnt++;
      tick();
      clear_inputs();
      @(negedge CLK);
      tot_cnt++;
      if (a_state !== 2'd0) $display("FAIL load_use_return: state=%0d want 0", a_state);
      else pass_cnt++;
      EX_MEM_READ = 1; EX_RD = 0; ID_RS1 = 0; ID_USES_RS1 = 1;
      #1;
      tot_cnt++;
      if (a_pc !== 1'b0 || a_bub !== 1'b0) $display("FAIL load_use_x0: pc=%b bub=%b want 0/0", a_pc, a_bub);
      else pass_cnt++;
      clear_inputs();
      EX_MEM_READ = 1; EX_RD = 5; ID_RS2 = 5; ID_USES_RS2 = 0;
      #1;
      tot_cnt++;
      if (a_pc !== 1'b0) $display("FAIL load_use_rs2_unused: pc=%b want 0", a_pc);
      else pass_cnt++;
      ID_USES_RS2 = 1;
      #1;
      tot_cnt++;
      if (a_pc !== 1'b1 || a_bub !== 1'b1) $display("FAIL load_use_rs2: pc=%b bub=%b want 1/1", a_pc, a_bub);
      else pass_cnt++;
      EX_MEM_READ = 0;
      #1;
      tot_cnt++;
      if (a_pc !== 1'b0) $display("FAIL load_use_not_load: pc=%b want 0", a_pc);
      else pass_cnt++;
      drain(2);
   endtask

   task automatic test_branch_priority();
      clear_inputs();
      EX_MEM_READ = 1; EX_RD = 7; ID_RS1 = 7; ID_USES_RS1 = 1; EX_BRANCH_TAKEN = 1;
      @(negedge CLK);
      tot_cnt++;
      if ({a_iff, a_idf, a_pc, a_ifid, a_bub} !== 5'b11000)
         $display("FAIL branch_priority: iff/idf/pc/ifid/bub=%b%b%b%b%b want 11000", a_iff, a_idf, a_pc, a_ifid, a_bub);
      else pass_cnt++;
      tick();
      @(negedge CLK);
      tot_cnt++;
      if (a_state !== 2'd0) $display("FAIL branch_next_state: state=%0d want 0", a_state);
      else pass_cnt++;
      drain(2);
   endtask

   task automatic test_divide();
      int stalls, starts;
      stalls = 0; starts = 0;
      clear_inputs();
      EX_DIV = 1;
      for (int c = 1; c <= 32; c++) begin
         @(negedge CLK);
         if (a_pc && a_exs && a_ifid) stalls++;
         if (a_start) starts++;
         tick();
      end
      @(negedge CLK);
      tot_cnt++;
      if (stalls !== 32) $display("FAIL div_stall_cycles: got %0d want 32", stalls);
      else pass_cnt++;
      tot_cnt++;
      if (starts !== 1) $display("FAIL div_start_pulses: got %0d want 1", starts);
      else pass_cnt++;
      tot_cnt++;
      if ({a_state, a_start, a_pc, a_busy} !== {2'd3, 3'b000})
         $display("FAIL div_done: state=%0d start=%b pc=%b busy=%b want 3/0/0/0", a_state, a_start, a_pc, a_busy);
      else pass_cnt++;
      tick();
      EX_DIV = 0;
      @(negedge CLK);
      tot_cnt++;
      if (a_state !== 2'd0 || a_pc !== 1'b0) $display("FAIL div_return: state=%0d pc=%b want 0/0", a_state, a_pc);
      else pass_cnt++;
      drain(40);
   endtask

   task automatic test_div1();
      clear_inputs();
      EX_DIV = 1;
      @(negedge CLK);
      tot_cnt++;
      if ({b_start, b_pc, b_exs, b_busy, b_state} !== {4'b1111, 2'd0})
         $display("FAIL div1_start: start/pc/exs/busy/state=%b%b%b%b/%0d want 1111/0", b_start, b_pc, b_exs, b_busy, b_state);
      else pass_cnt++;
      tick();
      EX_DIV = 0;
      @(negedge CLK);
      tot_cnt++;
      if ({b_state, b_start, b_pc} !== {2'd3, 2'b00}) $display("FAIL div1_done: state=%0d start=%b pc=%b want 3/0/0", b_state, b_start, b_pc);
      else pass_cnt++;
      tick();
      @(negedge CLK);
      tot_cnt++;
      if (b_state !== 2'd0) $display("FAIL div1_return: state=%0d want 0", b_state);
      else pass_cnt++;
      drain(40);
   endtask

   task automatic test_back_to_back();
      int first, second, cnt;
      first = -1; second = -1; cnt = 0;
      clear_inputs();
      EX_DIV = 1;
      for (int c = 0; c < 70; c++) begin
         @(negedge CLK);
         if (a_start) begin
            if (first < 0) first = c;
            else if (second < 0) second = c;
            cnt++;
         end
         tick();
      end
      tot_cnt++;
      if (second - first !== 33) $display("FAIL b2b_gap: got %0d want 33", second - first);
      else pass_cnt++;
      tot_cnt++;
      if (cnt !== 3) $display("FAIL b2b_count: got %0d want 3", cnt);
      else pass_cnt++;
      drain(40);
   endtask

   task automatic test_reset_mid_divide();
      clear_inputs();
      EX_DIV = 1;
      tick();
      EX_DIV = 0;
      for (int i = 0; i < 9; i++) tick();
      @(negedge CLK);
      tot_cnt++;
      if (a_state !== 2'd2 || a_pc !== 1'b1) $display("FAIL mid_div_wait: state=%0d pc=%b want 2/1", a_state, a_pc);
      else pass_cnt++;
      #2;
      RST = 1'b0;
      #1;
      tot_cnt++;
      if (obs[0] !== 10'd0) $display("FAIL mid_div_reset: got %h want 000", obs[0]);
      else pass_cnt++;
      tick();
      RST = 1'b1;
      @(negedge CLK);
      tot_cnt++;
      if (a_state !== 2'd0 || a_busy !== 1'b0) $display("FAIL mid_div_resume: state=%0d busy=%b want 0/0", a_state, a_busy);
      else pass_cnt++;
      EX_DIV = 1;
      #1;
      tot_cnt++;
      if (a_start !== 1'b1) $display("FAIL mid_div_restart: start=%b want 1", a_start);
      else pass_cnt++;
      tick();
      drain(40);
   endtask

   task automatic test_random();
      int errs [2];
      logic [9:0] exp;
      errs[0] = 0; errs[1] = 0;
      for (int n = 0; n < 4000; n++) begin
         ID_RS1          = 5'($urandom_range(0, 3));
         ID_RS2          = 5'($urandom_range(0, 3));
         EX_RD           = 5'($urandom_range(0, 3));
         ID_USES_RS1     = 1'($urandom_range(0, 1));
         ID_USES_RS2     = 1'($urandom_range(0, 1));
         EX_MEM_READ     = 1'($urandom_range(0, 1));
         EX_DIV          = ($urandom_range(0, 15) == 0);
         EX_BRANCH_TAKEN = ($urandom_range(0, 3) == 0);
         RST             = ($urandom_range(0, 127) != 0);
         @(negedge CLK);
         for (int k = 0; k < 2; k++) begin
            exp = model_out(k);
            tot_cnt++;
            if (obs[k] !== exp) begin
               if (errs[k] < 10) $display("FAIL random_dut%0d cycle %0d: got %b want %b", k, n, obs[k], exp);
               errs[k]++;
            end else pass_cnt++;
         end
         tick();
      end
      RST = 1'b1;
      drain(40);
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_load_use();
      test_branch_priority();
      test_divide();
      test_div1();
      test_back_to_back();
      test_reset_mid_divide();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
